// File: rtl/lives_score_tracker.sv
// Lives, score, combo and high-score bookkeeping for the fruit game.
// Tracks game phase from the flow FSM and turns fruit events into outputs.
module lives_score_tracker #(
  parameter int MAX_LIVES  = 3,
  parameter int SCORE_W    = 10,
  parameter int COMBO_WIN  = 25000000,
  parameter int INVULN_CYC = 25000000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start_screen,
  input  logic               throw_fruit,
  input  logic               end_screen,
  input  logic               slice_evt,
  input  logic               miss_evt,
  input  logic               bomb_evt,
  output logic [2:0]         lives,
  output logic               start_cut,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [2:0]         combo,
  output logic               invuln,
  output logic               life_lost
);

  localparam int CW = $clog2(COMBO_WIN + 1);
  localparam int IW = $clog2(INVULN_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } phase_t;

  phase_t             r_phase, w_phase;
  logic [2:0]         r_lives, w_lives;
  logic               r_start_cut, w_start_cut;
  logic [SCORE_W-1:0] r_score, w_score;
  logic [SCORE_W-1:0] r_high, w_high;
  logic [2:0]         r_combo, w_combo;
  logic               r_invuln, w_invuln;
  logic               r_life_lost, w_life_lost;
  logic [CW-1:0]      r_ctmr, w_ctmr;
  logic [IW-1:0]      r_itmr, w_itmr;

  logic               w_sel_done;
  logic               w_sel_play;
  logic               w_sel_idle;
  logic [SCORE_W-1:0] w_base;
  logic               w_alive;
  logic               w_bomb;
  logic               w_miss;
  logic [2:0]         w_cinc;
  logic [2:0]         w_add;
  logic [SCORE_W:0]   w_sum;

  assign w_sel_done = end_screen;
  assign w_sel_play = throw_fruit & ~end_screen;
  assign w_sel_idle = start_screen & ~throw_fruit & ~end_screen;

  // Score restarts from zero on the first play cycle after the start screen.
  assign w_base  = (r_phase == IDLE) ? '0 : r_score;
  assign w_alive = (r_lives != 3'd0);
  assign w_bomb  = bomb_evt & w_alive;
  assign w_miss  = miss_evt & w_alive & ~r_invuln & ~bomb_evt;
  assign w_cinc  = (r_ctmr == '0)     ? 3'd0 :
                   (r_combo == 3'd7)  ? 3'd7 :
                   r_combo + 3'd1;
  // A slice landing with a real miss scores on the combo it had before.
  assign w_add   = w_miss ? r_combo : w_cinc;
  assign w_sum   = {1'b0, w_base} + (SCORE_W+1)'(w_add)
                 + (SCORE_W+1)'(1);

  always_comb begin
    w_phase     = r_phase;
    w_lives     = r_lives;
    w_start_cut = 1'b0;
    w_score     = r_score;
    w_high      = r_high;
    w_combo     = r_combo;
    w_invuln    = r_invuln;
    w_life_lost = 1'b0;
    w_ctmr      = r_ctmr;
    w_itmr      = r_itmr;
    unique case (1'b1)
      w_sel_done: begin
        w_phase = DONE;
        if (r_score > r_high) w_high = r_score;
      end
      w_sel_play: begin
        w_phase = PLAY;
        w_score = w_base;
        if (slice_evt) begin
          w_score = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
        end
        if (w_bomb | w_miss) begin
          w_combo = 3'd0;
          w_ctmr  = '0;
        end else if (slice_evt) begin
          w_combo = w_cinc;
          w_ctmr  = CW'(COMBO_WIN);
        end else if (r_ctmr != '0) begin
          w_ctmr = r_ctmr - 1'b1;
          if (r_ctmr == CW'(1)) w_combo = 3'd0;
        end
        if (w_miss) begin
          w_invuln = 1'b1;
          w_itmr   = IW'(INVULN_CYC);
        end else if (r_itmr != '0) begin
          w_itmr = r_itmr - 1'b1;
          if (r_itmr == IW'(1)) w_invuln = 1'b0;
        end
        if (w_bomb) begin
          w_lives     = 3'd0;
          w_life_lost = 1'b1;
        end else if (w_miss) begin
          w_lives     = r_lives - 3'd1;
          w_life_lost = 1'b1;
        end
      end
      w_sel_idle: begin
        w_phase     = IDLE;
        w_lives     = 3'(MAX_LIVES);
        w_combo     = 3'd0;
        w_invuln    = 1'b0;
        w_ctmr      = '0;
        w_itmr      = '0;
        w_start_cut = slice_evt & ~r_start_cut;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_phase     <= IDLE;
      r_lives     <= 3'(MAX_LIVES);
      r_start_cut <= 1'b0;
      r_score     <= '0;
      r_high      <= '0;
      r_combo     <= 3'd0;
      r_invuln    <= 1'b0;
      r_life_lost <= 1'b0;
      r_ctmr      <= '0;
      r_itmr      <= '0;
    end else begin
      r_phase     <= w_phase;
      r_lives     <= w_lives;
      r_start_cut <= w_start_cut;
      r_score     <= w_score;
      r_high      <= w_high;
      r_combo     <= w_combo;
      r_invuln    <= w_invuln;
      r_life_lost <= w_life_lost;
      r_ctmr      <= w_ctmr;
      r_itmr      <= w_itmr;
    end
  end

  assign lives      = r_lives;
  assign start_cut  = r_start_cut;
  assign score      = r_score;
  assign high_score = r_high;
  assign combo      = r_combo;
  assign invuln     = r_invuln;
  assign life_lost  = r_life_lost;

endmodule

// File: tb/tb_lives_score_tracker.sv
// Scoreboard bench for lives_score_tracker with short combo/invuln windows.
module tb_lives_score_tracker;

  localparam int SW = 10;
  localparam int F_LIV = 0;
  localparam int F_SC  = 1;
  localparam int F_SCR = 2;
  localparam int F_HI  = 3;
  localparam int F_CMB = 4;
  localparam int F_INV = 5;
  localparam int F_LL  = 6;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          ss = 1'b0, tf = 1'b0, es = 1'b0;
  logic          sl = 1'b0, mi = 1'b0, bo = 1'b0;
  logic [2:0]    lives;
  logic          start_cut;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;
  logic [2:0]    combo;
  logic          invuln;
  logic          life_lost;

  always #5 Clk = ~Clk;

  lives_score_tracker #(
    .MAX_LIVES(3), .SCORE_W(SW),
    .COMBO_WIN(8), .INVULN_CYC(16)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .start_screen(ss), .throw_fruit(tf), .end_screen(es),
    .slice_evt(sl), .miss_evt(mi), .bomb_evt(bo),
    .lives(lives), .start_cut(start_cut), .score(score),
    .high_score(high_score), .combo(combo),
    .invuln(invuln), .life_lost(life_lost)
  );

  typedef struct {
    string nm;
    int    f;
    int    v;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void push(string nm, int f, int v);
    exp_t e;
    e.nm = nm; e.f = f; e.v = v;
    sbq.push_back(e);
  endfunction

  function automatic logic [31:0] obs(int f);
    case (f)
      F_LIV:   return {29'd0, lives};
      F_SC:    return {31'd0, start_cut};
      F_SCR:   return {22'd0, score};
      F_HI:    return {22'd0, high_score};
      F_CMB:   return {29'd0, combo};
      F_INV:   return {31'd0, invuln};
      default: return {31'd0, life_lost};
    endcase
  endfunction

  task automatic phase(input logic s, input logic t, input logic e);
    ss = s; tf = t; es = e;
  endtask

  task automatic evt(input logic a, input logic b, input logic c);
    sl = a; mi = b; bo = c;
  endtask

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    phase(0, 0, 0);
    evt(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        push("rst lives", F_LIV, 3);
        push("rst start_cut", F_SC, 0);
        push("rst score", F_SCR, 0);
        push("rst high", F_HI, 0);
        push("rst combo", F_CMB, 0);
        push("rst invuln", F_INV, 0);
        push("rst life_lost", F_LL, 0);
      end
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
  endtask

  task automatic test_start;
    Reset = 1'b1;
    phase(1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      evt(k == 1 || k == 2, k == 4, k == 4);
      push($sformatf("start lives k%0d", k), F_LIV, 3);
      push($sformatf("start_cut k%0d", k), F_SC, (k == 1) ? 1 : 0);
      if (k == 1) push("start score", F_SCR, 0);
      if (k == 4) push("start life_lost", F_LL, 0);
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
  endtask

  task automatic test_combo;
    phase(0, 1, 0);
    for (int k = 0; k < 21; k++) begin
      evt(k inside {0, 3, 6, 20}, 0, 0);
      case (k)
        0:  begin push("cmb k0", F_CMB, 0); push("scr k0", F_SCR, 1); end
        3:  begin push("cmb k3", F_CMB, 1); push("scr k3", F_SCR, 3); end
        6:  begin push("cmb k6", F_CMB, 2); push("scr k6", F_SCR, 6); end
        13: push("cmb k13", F_CMB, 2);
        14: push("cmb expire k14", F_CMB, 0);
        20: begin
          push("cmb k20", F_CMB, 0);
          push("scr k20", F_SCR, 7);
          push("lives k20", F_LIV, 3);
        end
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    evt(0, 0, 0);
  endtask

  task automatic test_miss;
    phase(0, 1, 0);
    for (int k = 0; k < 22; k++) begin
      evt(0, k inside {0, 5, 20}, 0);
      case (k)
        0: begin
          push("miss lives k0", F_LIV, 2);
          push("miss ll k0", F_LL, 1);
          push("miss inv k0", F_INV, 1);
        end
        1: begin
          push("miss ll k1", F_LL, 0);
          push("miss inv k1", F_INV, 1);
        end
        5: begin
          push("miss ignored lives", F_LIV, 2);
          push("miss ignored ll", F_LL, 0);
        end
        15: push("inv k15", F_INV, 1);
        16: push("inv drop k16", F_INV, 0);
        20: begin
          push("miss lives k20", F_LIV, 1);
          push("miss ll k20", F_LL, 1);
          push("miss inv k20", F_INV, 1);
          push("miss score k20", F_SCR, 7);
        end
        21: push("miss ll k21", F_LL, 0);
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    evt(0, 0, 0);
  endtask

  task automatic test_bomb;
    for (int k = -1; k < 5; k++) begin
      if (k < 0) phase(1, 0, 0);
      else phase(0, 1, 0);
      evt(0, k == 0 || k == 3, k == 1 || k == 4);
      case (k)
        -1: push("bomb idle lives", F_LIV, 3);
        0: begin
          push("bomb pre lives", F_LIV, 2);
          push("bomb pre inv", F_INV, 1);
          push("bomb entry score", F_SCR, 0);
        end
        1: begin
          push("bomb lives", F_LIV, 0);
          push("bomb ll", F_LL, 1);
        end
        2: push("bomb ll k2", F_LL, 0);
        default: begin
          push($sformatf("dead lives k%0d", k), F_LIV, 0);
          push($sformatf("dead ll k%0d", k), F_LL, 0);
        end
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    evt(0, 0, 0);
  endtask

  task automatic test_simultaneous;
    for (int k = -1; k < 5; k++) begin
      if (k < 0) phase(1, 0, 0);
      else phase(0, 1, 0);
      if (k < 0) evt(0, 0, 0);
      else evt(1, k == 3, k == 4);
      case (k)
        -1: push("sim idle lives", F_LIV, 3);
        2: begin
          push("sim combo k2", F_CMB, 2);
          push("sim score k2", F_SCR, 6);
        end
        3: begin
          push("slice+miss score", F_SCR, 9);
          push("slice+miss lives", F_LIV, 2);
          push("slice+miss combo", F_CMB, 0);
          push("slice+miss ll", F_LL, 1);
        end
        4: begin
          push("slice+bomb score", F_SCR, 10);
          push("slice+bomb lives", F_LIV, 0);
          push("slice+bomb ll", F_LL, 1);
        end
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    evt(0, 0, 0);
  endtask

  // Steps: 0 idle, 1..14 game one, 15 end, 16 hold, 17 idle,
  // 18..42 game two, 43 end.
  task automatic test_high_score;
    for (int k = 0; k < 44; k++) begin
      evt(0, 0, 0);
      if (k == 0 || k == 17) phase(1, 0, 0);
      else if (k == 15 || k == 43) phase(0, 0, 1);
      else if (k == 16) begin
        phase(0, 0, 0);
        evt(1, 0, 0);
      end else begin
        phase(0, 1, 0);
        if (k <= 14) evt((k - 1) inside {0, 1, 2, 13}, 0, 0);
        else evt((k - 19) inside {0, 1, 12, 23}, 0, 0);
      end
      case (k)
        0:  push("hi idle score held", F_SCR, 10);
        14: push("hi game1 score", F_SCR, 7);
        15: begin
          push("hi after game1", F_HI, 7);
          push("hi end score held", F_SCR, 7);
        end
        16: begin
          push("hold score", F_SCR, 7);
          push("hold start_cut", F_SC, 0);
          push("hold high", F_HI, 7);
        end
        17: push("idle2 score held", F_SCR, 7);
        18: begin
          push("play entry score", F_SCR, 0);
          push("play entry lives", F_LIV, 3);
        end
        42: push("hi game2 score", F_SCR, 5);
        43: begin
          push("hi kept", F_HI, 7);
          push("hi game2 held", F_SCR, 5);
        end
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    phase(0, 0, 0);
  endtask

  // 140 back-to-back slices: combo saturates at 7 and score at 1023.
  task automatic test_saturate;
    for (int k = -1; k < 141; k++) begin
      if (k < 0) phase(1, 0, 0);
      else if (k == 140) phase(0, 0, 1);
      else phase(0, 1, 0);
      evt(k >= 0 && k < 140, 0, 0);
      case (k)
        6:   push("sat score k6", F_SCR, 28);
        7: begin
          push("sat combo k7", F_CMB, 7);
          push("sat score k7", F_SCR, 36);
        end
        139: begin
          push("sat combo end", F_CMB, 7);
          push("sat score max", F_SCR, 1023);
        end
        140: push("sat high", F_HI, 1023);
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_game;
    for (int k = 0; k < 3; k++) begin
      phase(0, 1, 0);
      evt(1, k == 2, 0);
      Reset = (k == 1) ? 1'b0 : 1'b1;
      case (k)
        1: begin
          push("mid rst lives", F_LIV, 3);
          push("mid rst score", F_SCR, 0);
          push("mid rst high", F_HI, 0);
          push("mid rst combo", F_CMB, 0);
        end
        2: begin
          push("post rst score", F_SCR, 1);
          push("post rst lives", F_LIV, 2);
        end
        default: ;
      endcase
      tick();
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_chk++;
        if (obs(e.f) !== 32'(e.v)) begin
          n_fail++;
          $display("FAIL %s: got %0d expected %0d", e.nm, obs(e.f), e.v);
        end
      end
    end
    evt(0, 0, 0);
    phase(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_combo();
    test_miss();
    test_bomb();
    test_simultaneous();
    test_high_score();
    test_saturate();
    test_reset_mid_game();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
